// File: rtl/display_scan_if.sv
// ============================================================================
// Module   : display_scan_if
// Brief    : BCD digit inputs and multiplexed 7-segment outputs of display_scan.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface display_scan_if;
    logic       enable;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [3:0] display_colune;
    logic [6:0] display_data;
    logic       frame_start;

    modport master (
        output enable, dig0, dig1, dig2, dig3,
        input  display_colune, display_data, frame_start
    );

    modport slave (
        input  enable, dig0, dig1, dig2, dig3,
        output display_colune, display_data, frame_start
    );
endinterface

`default_nettype wire

// File: rtl/display_scan.sv
// ============================================================================
// Module   : display_scan
// Brief    : 4-digit 7-segment scanner with per-slot dark interval, per-frame
//            digit snapshot and leading-zero blanking of the tens digits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module display_scan #(
    parameter int SCAN_DIV     = 12500,
    parameter int BLANK_CYCLES = 64,
    parameter int LZ_BLANK     = 1
) (
    input  wire logic      clk,
    input  wire logic      reset,
    display_scan_if.slave  bus
);

    localparam int            CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] C_BLANK    = CW'(BLANK_CYCLES);
    localparam logic [6:0]    C_SEG_OFF  = 7'b1111111;

    logic [CW-1:0]       cnt_q,    cnt_d;
    logic [1:0]          slot_q,   slot_d;
    logic [3:0][3:0]     snap_q,   snap_d;
    logic [3:0]          colune_q, colune_d;
    logic [6:0]          data_q,   data_d;
    logic                fs_q,     fs_d;

    logic                w_tick;
    logic [3:0]          w_digit;
    logic                w_lz;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111110;
        endcase
        return s;
    endfunction

    assign w_tick  = (cnt_q == C_CNT_LAST);
    assign w_digit = snap_q[slot_q];
    // Even slots hold the tens digits; a zero there is suppressed but the column stays driven.
    assign w_lz    = (LZ_BLANK != 0) && !slot_q[0] && (w_digit == 4'd0);

    always_comb begin
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        snap_d   = snap_q;
        colune_d = 4'b0000;
        data_d   = C_SEG_OFF;
        fs_d     = 1'b0;

        if (!bus.enable) begin
            cnt_d  = '0;
            slot_d = 2'd0;
            snap_d = {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
        end else begin
            if (w_tick) begin
                cnt_d  = '0;
                slot_d = slot_q + 2'd1;
                if (slot_q == 2'd3) begin
                    snap_d = {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
                    fs_d   = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            if (cnt_q >= C_BLANK) begin
                colune_d = 4'b1000 >> slot_q;
                data_d   = w_lz ? C_SEG_OFF : seg_decode(w_digit);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            slot_q   <= 2'd0;
            snap_q   <= '0;
            colune_q <= 4'b0000;
            data_q   <= C_SEG_OFF;
            fs_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            snap_q   <= snap_d;
            colune_q <= colune_d;
            data_q   <= data_d;
            fs_q     <= fs_d;
        end
    end

    assign bus.display_colune = colune_q;
    assign bus.display_data   = data_q;
    assign bus.frame_start    = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan.sv
// ============================================================================
// Module   : tb_display_scan
// Brief    : Directed self-checking bench for display_scan (two instances, LZ on/off).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_display_scan;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SD = 7'b1111110;
    localparam logic [6:0] SB = 7'b1111111;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   cyc;

    display_scan_if if0 ();
    display_scan_if if1 ();

    assign if1.enable = if0.enable;
    assign if1.dig0   = if0.dig0;
    assign if1.dig1   = if0.dig1;
    assign if1.dig2   = if0.dig2;
    assign if1.dig3   = if0.dig3;

    display_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    display_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(0)) u_dut_nolz (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock of a running scan; cyc counts cycles since the enable rise.
    task automatic step(input logic [27:0] segs, input logic [27:0] segs_nolz);
        int         pos;
        int         slot;
        int         c;
        logic [3:0] ec;
        logic [6:0] ed;
        logic [6:0] en;
        logic       efs;
        @(posedge clk);
        #1;
        pos  = cyc % 32;
        slot = pos / 8;
        c    = pos % 8;
        if (c < 2) begin
            ec = 4'b0000;
            ed = SB;
            en = SB;
        end else begin
            ec = 4'b1000 >> slot;
            ed = segs[27 - 7*slot -: 7];
            en = segs_nolz[27 - 7*slot -: 7];
        end
        efs = (pos == 31);
        check($sformatf("scan c%0d", cyc), {if0.frame_start, if0.display_colune, if0.display_data},
              {efs, ec, ed});
        check($sformatf("nolz c%0d", cyc), {if1.frame_start, if1.display_colune, if1.display_data},
              {efs, ec, en});
        cyc++;
    endtask

    task automatic frame(input logic [27:0] segs, input logic [27:0] segs_nolz);
        for (int k = 0; k < 32; k++) step(segs, segs_nolz);
    endtask

    task automatic set_digs(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        if0.dig0 = a;
        if0.dig1 = b;
        if0.dig2 = c;
        if0.dig3 = d;
    endtask

    task automatic check_dark(input string tag);
        @(posedge clk);
        #1;
        check(tag, {if0.frame_start, if0.display_colune, if0.display_data}, {1'b0, 4'b0000, SB});
        check({tag, "_nolz"}, {if1.frame_start, if1.display_colune, if1.display_data},
              {1'b0, 4'b0000, SB});
    endtask

    initial begin
        logic [27:0] p1234;
        logic [27:0] p1237;
        logic [27:0] p0500;
        logic [27:0] p0500n;
        logic [27:0] p8965;
        logic [27:0] p12c4;
        p1234  = {S1, S2, S3, S4};
        p1237  = {S1, S2, S3, S7};
        p0500  = {SB, S5, SB, S0};
        p0500n = {S0, S5, S0, S0};
        p8965  = {S8, S9, S6, S5};
        p12c4  = {S1, S2, SD, S4};
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        reset     = 1'b1;
        if0.enable = 1'b0;
        set_digs(4'd0, 4'd0, 4'd0, 4'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {if0.frame_start, if0.display_colune, if0.display_data}, {1'b0, 4'b0000, SB});

        // Basic scan of 1,2,3,4 over two frames
        set_digs(4'd1, 4'd2, 4'd3, 4'd4);
        reset = 1'b0;
        check_dark("disabled");
        if0.enable = 1'b1;
        cyc = 0;
        frame(p1234, p1234);
        frame(p1234, p1234);

        // Asynchronous reset mid-slot (while slot 1 is lit)
        for (int k = 0; k < 11; k++) step(p1234, p1234);
        check("pre_reset_lit", {28'd0, if0.display_colune}, 32'(4'b0100));
        reset      = 1'b1;
        if0.enable = 1'b0;
        #1;
        check("async_reset", {if0.frame_start, if0.display_colune, if0.display_data}, {1'b0, 4'b0000, SB});
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_dark("post_reset");
        if0.enable = 1'b1;
        cyc = 0;
        frame(p1234, p1234);

        // Leading-zero blanking, loaded through an enable drop
        set_digs(4'd0, 4'd5, 4'd0, 4'd0);
        if0.enable = 1'b0;
        check_dark("lz_load");
        if0.enable = 1'b1;
        cyc = 0;
        frame(p0500, p0500n);

        // Digits change mid-frame only appear after the next snapshot
        set_digs(4'd1, 4'd2, 4'd3, 4'd4);
        frame(p0500, p0500n);
        for (int k = 0; k < 11; k++) step(p1234, p1234);
        if0.dig3 = 4'd7;
        for (int k = 0; k < 21; k++) step(p1234, p1234);
        frame(p1237, p1237);

        // Enable drop in slot 2; rise while digits change in the same cycle
        for (int k = 0; k < 20; k++) step(p1237, p1237);
        if0.enable = 1'b0;
        set_digs(4'd8, 4'd9, 4'd6, 4'd5);
        for (int k = 0; k < 4; k++) check_dark("en_low");
        if0.enable = 1'b1;
        set_digs(4'd1, 4'd2, 4'd3, 4'd4);
        cyc = 0;
        frame(p8965, p8965);
        frame(p1234, p1234);

        // Non-BCD values show a dash, and are not blanked in a tens slot
        if0.dig2 = 4'hC;
        frame(p1234, p1234);
        if0.dig2 = 4'd10;
        frame(p12c4, p12c4);
        frame(p12c4, p12c4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
